// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port data RAM between the CPU load/store path and a debug/host port.
// The CPU has default priority. A starvation counter forces a debug slot after MAXWAIT
// consecutive blocked debug cycles, and the CPU is stalled for that slot. After every
// debug grant the arbiter spends one HOLD cycle in which debug cannot be granted, so the
// CPU always makes forward progress.
//
// Optional feature (macro ARB_STATS_EN): adds saturating 8-bit counters stall_cnt
// (cycles with cpu_stall=1) and dbg_cnt (dbg_gnt pulses). When the macro is undefined,
// both ports and both counters are absent.
//
// Ports:
//   clk, nreset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU access request (lw|sw)
//   cpu_gnt, cpu_stall          CPU access performed / CPU must freeze this cycle
//   cpu_rdata                   combinational read data (valid when cpu_gnt=1)
//   dbg_req/we/addr/wdata       debug request, level, held until dbg_gnt
//   dbg_gnt                     debug access performed this cycle
//   dbg_rvalid, dbg_rdata       registered debug read result, one cycle after grant
//   stall_cnt, dbg_cnt          statistics counters (ARB_STATS_EN only)
//   ram_addr/din/we, ram_dout   RAM interface (RAM writes on posedge, reads combinationally)

module ram_port_arbiter #(
  parameter int unsigned n       = 8,
  parameter int unsigned Asize   = 8,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic             clk,
  input  logic             nreset,
  // CPU port
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [Asize-1:0] cpu_addr,
  input  logic [n-1:0]     cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic [n-1:0]     cpu_rdata,
  // Debug port
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [Asize-1:0] dbg_addr,
  input  logic [n-1:0]     dbg_wdata,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [n-1:0]     dbg_rdata,
`ifdef ARB_STATS_EN
  output logic [7:0]       stall_cnt,
  output logic [7:0]       dbg_cnt,
`endif
  // RAM port
  output logic [Asize-1:0] ram_addr,
  output logic [n-1:0]     ram_din,
  output logic             ram_we,
  input  logic [n-1:0]     ram_dout
);

  localparam logic ARB  = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam logic [3:0] MaxWait = 4'(MAXWAIT);

  logic             state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic [n-1:0]     dbg_rdata_q, dbg_rdata_d;
  logic             wait_at_max;

  assign wait_at_max = (wait_cnt_q == MaxWait);

  // Grant decode. HOLD blocks debug even when the CPU is idle.
  always_comb begin
    dbg_gnt   = (state_q == ARB) & dbg_req & (~cpu_req | wait_at_max);
    cpu_gnt   = cpu_req & ~dbg_gnt;
    cpu_stall = cpu_req & dbg_gnt;
  end

  // RAM mux. A stalled CPU write never reaches the RAM because the debug side owns
  // the port in that cycle.
  always_comb begin
    if (dbg_gnt) begin
      ram_addr = dbg_addr;
      ram_din  = dbg_wdata;
      ram_we   = dbg_we;
    end else begin
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      ram_we   = cpu_we & cpu_req;
    end
  end

  assign cpu_rdata = ram_dout;

  // Next state
  always_comb begin
    state_d = ARB;
    unique case (state_q)
      ARB:     state_d = dbg_gnt ? HOLD : ARB;
      HOLD:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Starvation counter: counts blocked debug cycles, clears on grant or withdrawal.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (dbg_req && !dbg_gnt) begin
      wait_cnt_d = wait_at_max ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  // Debug read capture. dbg_rdata keeps its value until the next debug read.
  always_comb begin
    dbg_rvalid_d = dbg_gnt & ~dbg_we;
    dbg_rdata_d  = dbg_rdata_q;
    if (dbg_gnt && !dbg_we) begin
      dbg_rdata_d = ram_dout;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ARB;
      wait_cnt_q   <= 4'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

`ifdef ARB_STATS_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] dbg_cnt_q, dbg_cnt_d;

  // Both counters saturate at 255.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    dbg_cnt_d   = dbg_cnt_q;
    if (cpu_stall && (stall_cnt_q != 8'hff)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
    if (dbg_gnt && (dbg_cnt_q != 8'hff)) begin
      dbg_cnt_d = dbg_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_cnt_q <= 8'd0;
      dbg_cnt_q   <= 8'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      dbg_cnt_q   <= dbg_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dbg_cnt   = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter. The RAM is modelled as a plain array driven by
// the DUT's RAM port; expected behaviour comes from an independent reference model that
// tracks blocked-cycle count, the post-grant cycle and a reference copy of memory.
// Build with +define+ARB_STATS_EN to also check the statistics counters.

module tb_ram_port_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [N-1:0]  cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic [N-1:0]  ram_din, ram_dout;
  logic          ram_we;
`ifdef ARB_STATS_EN
  logic [7:0]    stall_cnt, dbg_cnt;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .n       (N),
    .Asize   (AW),
    .MAXWAIT (MW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
`ifdef ARB_STATS_EN
    .stall_cnt  (stall_cnt),
    .dbg_cnt    (dbg_cnt),
`endif
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  // Environment RAM: combinational read, posedge write
  logic [N-1:0] mem [256];
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  // Reference model state
  logic [N-1:0] ref_mem [256];
  int           waited;     // consecutive blocked debug cycles
  bit           after_dbg;  // previous cycle granted debug
  bit           m_rvalid;
  logic [N-1:0] m_rdata;
  int           stall_n, dgnt_n;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    waited    = 0;
    after_dbg = 0;
    m_rvalid  = 0;
    m_rdata   = '0;
    stall_n   = 0;
    dgnt_n    = 0;
  endtask

  task automatic drive_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    nreset = 0;
    model_reset();
    @(negedge clk);
    #1 nreset = 1;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model.
  task automatic step(input bit creq, input bit cwe, input logic [7:0] caddr,
                      input logic [7:0] cwd, input bit dreq, input bit dwe,
                      input logic [7:0] daddr, input logic [7:0] dwd, output bit granted);
    bit eg, ewe;
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    #1;
    eg  = !after_dbg && dreq && (!creq || waited >= MW);
    ewe = eg ? dwe : (creq && cwe);
    check_eq("dbg_gnt", dbg_gnt, eg);
    check_eq("cpu_gnt", cpu_gnt, creq && !eg);
    check_eq("cpu_stall", cpu_stall, creq && eg);
    check_eq("ram_we", ram_we, ewe);
    check_eq("ram_addr", ram_addr, eg ? daddr : caddr);
    check_eq("ram_din", ram_din, eg ? dwd : cwd);
    check_eq("dbg_rvalid", dbg_rvalid, m_rvalid);
    check_eq("dbg_rdata", dbg_rdata, m_rdata);
    if (creq && !eg && !cwe) check_eq("cpu_rdata", cpu_rdata, ref_mem[caddr]);
`ifdef ARB_STATS_EN
    check_eq("stall_cnt", stall_cnt, sat255(stall_n));
    check_eq("dbg_cnt", dbg_cnt, sat255(dgnt_n));
`endif
    // Advance model to the state after this cycle's posedge
    m_rvalid = eg && !dwe;
    if (eg && !dwe) m_rdata = ref_mem[daddr];
    if (eg && dwe) ref_mem[daddr] = dwd;
    else if (!eg && creq && cwe) ref_mem[caddr] = cwd;
    if (dreq && !eg) waited = (waited + 1 > MW) ? MW : waited + 1;
    else waited = 0;
    after_dbg = eg;
    if (creq && eg) stall_n++;
    if (eg) dgnt_n++;
    granted = eg;
  endtask

  initial begin
    bit           g;
    int           gcycle, ngnt;
    bit           pend, pwe;
    logic [7:0]   paddr, pwd;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    drive_idle();
    nreset = 0;
    model_reset();
    #12;

    // Reset state
    check_eq("rst_rvalid", dbg_rvalid, 0);
    check_eq("rst_rdata", dbg_rdata, 0);
    check_eq("rst_gnt", dbg_gnt, 0);
    @(negedge clk);
    #1 nreset = 1;

    // Debug write then read with an idle CPU
    step(0, 0, 0, 0, 1, 1, 8'h10, 8'hA5, g);
    check_eq("wr_gnt", g, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, 0, 8'h10, 8'h00, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
    check_eq("rd_rvalid", dbg_rvalid, 1);
    check_eq("rd_data", dbg_rdata, 8'hA5);

    // Busy CPU: debug forced at cycle MAXWAIT, then HOLD suppresses debug
    do_reset();
    gcycle = -1;
    for (int c = 0; c < 20 && gcycle < 0; c++) begin
      step(1, 0, 8'h05, 0, 1, 1, 8'h06, 8'h11, g);
      if (g) gcycle = c;
    end
    check_eq("force_cycle", gcycle, MW);
    step(1, 0, 8'h05, 0, 1, 1, 8'h06, 8'h11, g);
    check_eq("hold_no_gnt", g, 0);
    check_eq("hold_cpu_gnt", cpu_gnt, 1);

    // Forced slot collides with a CPU write to the same address
    do_reset();
    g = 0;
    for (int c = 0; c < 20 && !g; c++) step(1, 1, 8'h20, 8'h33, 1, 1, 8'h20, 8'h77, g);
    check_eq("slot_gnt", g, 1);
    @(posedge clk);
    #1 check_eq("mem_after_slot", mem[8'h20], 8'h77);
    step(1, 1, 8'h20, 8'h33, 0, 0, 0, 0, g);
    @(posedge clk);
    #1 check_eq("mem_after_replay", mem[8'h20], 8'h33);

    // Debug withdrawn before grant
    do_reset();
    ngnt = 0;
    for (int c = 0; c < 2; c++) begin
      step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, g);
      ngnt += int'(g);
    end
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 8'h01, 0, c == 1, 0, 8'h02, 0, g);
      ngnt += int'(g);
    end
    check_eq("drop_no_gnt", ngnt, 0);

    // Reset during a debug read grant cycle
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
    @(negedge clk);
    drive_idle();
    dbg_req = 1; dbg_addr = 8'h10;
    #1 check_eq("rstrd_gnt", dbg_gnt, 1);
    #1 nreset = 0;
    model_reset();
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("rstrd_rvalid", dbg_rvalid, 0);
    check_eq("rstrd_rdata", dbg_rdata, 0);
    nreset = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
    check_eq("rstrd_rvalid2", dbg_rvalid, 0);
    step(0, 0, 0, 0, 1, 0, 8'h10, 0, g);
    check_eq("rstrd_arb", g, 1);

`ifdef ARB_STATS_EN
    // Three forced slots, then saturation
    do_reset();
    for (int c = 0; c < 3 * (MW + 1); c++) step(1, 0, 8'h03, 0, 1, 1, 8'h04, 8'h55, g);
    @(posedge clk);
    #1;
    check_eq("stats_stall3", stall_cnt, 3);
    check_eq("stats_dbg3", dbg_cnt, 3);
    do_reset();
    for (int c = 0; c < 300 * (MW + 1); c++) step(1, 0, 8'h03, 0, 1, 1, 8'h04, 8'h55, g);
    @(posedge clk);
    #1;
    check_eq("stats_stall_sat", stall_cnt, 255);
    check_eq("stats_dbg_sat", dbg_cnt, 255);
`endif

    // Randomized traffic; debug requests held until granted, occasionally withdrawn
    do_reset();
    pend = 0; pwe = 0; paddr = 0; pwd = 0;
    for (int c = 0; c < 800; c++) begin
      if (!pend && ($urandom_range(0, 3) == 0)) begin
        pend  = 1;
        pwe   = 1'($urandom_range(0, 1));
        paddr = 8'($urandom_range(0, 15));
        pwd   = 8'($urandom);
      end else if (pend && ($urandom_range(0, 15) == 0)) begin
        pend = 0;
      end
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
           8'($urandom), pend, pwe, paddr, pwd, g);
      if (g) pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between the CPU load/store path (sw/lw) and a debug/host access port.
- Sits between the CPU datapath (ALU result as address, Rdata2 as write data) and the data RAM.
- CPU has default priority. A starvation counter forces a debug slot after MAXWAIT blocked cycles; during that slot the arbiter stalls the CPU.

Parameters:
- n, 8, data width
- Asize, 8, RAM address width
- MAXWAIT, 4, consecutive blocked debug cycles before a forced grant (legal 1..15)

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU memory access this cycle (lw|sw)
- cpu_we  in  1  CPU write (sw)
- cpu_addr  in  Asize  CPU address
- cpu_wdata  in  n  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  CPU must freeze PC and pipeline regs this cycle
- cpu_rdata  out  n  read data to CPU (lw)
- dbg_req  in  1  debug request, level, held until dbg_gnt
- dbg_we  in  1  debug write
- dbg_addr  in  Asize  debug address
- dbg_wdata  in  n  debug write data
- dbg_gnt  out  1  one-cycle pulse: debug access performed this cycle
- dbg_rvalid  out  1  one-cycle pulse the cycle after a debug read grant
- dbg_rdata  out  n  registered debug read data
- ram_addr  out  Asize  RAM address
- ram_din  out  n  RAM write data
- ram_we  out  1  RAM write enable (RAM writes on posedge clk)
- ram_dout  in  n  RAM read data (combinational read)

Behaviour:
- FSM states: ARB (normal arbitration) and HOLD (post-debug CPU-priority cycle). Reset state is ARB.
- wait_cnt: 4-bit register.
  - Increments in each cycle where dbg_req=1 and dbg_gnt=0, saturating at MAXWAIT.
  - Clears when dbg_gnt=1 or dbg_req=0.
- Debug grant (combinational): dbg_gnt = (state==ARB) & dbg_req & (!cpu_req | wait_cnt==MAXWAIT).
- Forced slot: when dbg_gnt & cpu_req, then cpu_stall=1 and cpu_gnt=0. The CPU access is not performed, so no write reaches the RAM, and the CPU replays it next cycle.
- cpu_gnt = cpu_req & !dbg_gnt.
- cpu_stall = cpu_req & dbg_gnt. It is never asserted in HOLD.
- RAM mux:
  - When dbg_gnt=1, ram_* carry dbg_addr, dbg_wdata and dbg_we.
  - Otherwise ram_* carry cpu_addr, cpu_wdata and (cpu_we & cpu_req).
  - ram_we is never 1 without a grant.
- cpu_rdata = ram_dout (combinational). Valid only when cpu_gnt=1.
- Debug read: at the posedge ending a dbg_gnt&!dbg_we cycle, dbg_rdata <= ram_dout and dbg_rvalid <= 1. dbg_rvalid is 0 otherwise. dbg_rdata holds its value until the next debug read.
- Transitions:
  - ARB -> HOLD when dbg_gnt=1.
  - HOLD -> ARB unconditionally.
  - In HOLD, debug is never granted, even with the CPU idle. This guarantees the CPU forward progress.
- Latency:
  - Debug write completes in the grant cycle.
  - Debug read data arrives 1 cycle after grant.
  - Minimum spacing between debug grants is 2 cycles.
- Worst-case debug wait from dbg_req rise with a continuously busy CPU is MAXWAIT cycles.
- Simultaneous cpu_req and dbg_req with wait_cnt<MAXWAIT: the CPU wins.
- dbg_req dropped before grant: wait_cnt clears and no access occurs.
- Reset (asynchronous, including mid-operation):
  - state=ARB, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0.
  - Combinational outputs follow the inputs with no grants pending.
  - A debug read in flight is lost; no rvalid pulse after reset.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [7:0], which counts cycles with cpu_stall=1 and saturates at 255.
  - Adds output dbg_cnt [7:0], which counts dbg_gnt pulses and saturates at 255.
  - Both counters reset to 0 on nreset.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

Test Plan:
- CPU idle, dbg write addr 8'h10 data 8'hA5 -> dbg_gnt same cycle, ram_we=1, ram_addr=8'h10. A subsequent dbg read of 8'h10 -> dbg_rvalid next cycle, dbg_rdata=8'hA5.
- cpu_req=1 every cycle, dbg_req rises at cycle 0, MAXWAIT=4 -> cpu_gnt in cycles 0-3. Cycle 4: dbg_gnt=1, cpu_stall=1, cpu_gnt=0. Cycle 5: HOLD, cpu_gnt=1, no dbg_gnt.
- Forced slot with cpu_we=1 addr 8'h20 data 8'h33, debug write 8'h20 data 8'h77 -> RAM holds 8'h77 after the slot and 8'h33 after the CPU replay cycle.
- Simultaneous cpu_req and dbg_req from reset, dbg_req dropped at cycle 2 -> no dbg_gnt, wait_cnt=0, no stall.
- nreset asserted during the debug read grant cycle -> dbg_rvalid stays 0, dbg_rdata=0, state ARB after release.
- ARB_STATS_EN defined, 3 forced slots -> stall_cnt=3, dbg_cnt=3. 300 forced slots -> both counters saturate at 255.
